pwm_scheduler: RTL and testbench
================================

Name: pwm_scheduler

Overview:
Owns the shared PWM time base and the compare values for a bank of timer channels. Generates the free-running counter and holds double-buffered rising/falling tick numbers per channel, written via a valid/ready port. Applies new values only at a period boundary, so downstream edge-compare timer instances never see a torn period. Sits between the register/config interface and the timer instances.

Parameters:
bitwidth, 10, width of counter, period and tick numbers
channels, 4, number of timer channels served
chan_index_width, 2, width of wr_channel; 2**chan_index_width >= channels

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  level; 1 = run time base
period  input  bitwidth  counter top value; sampled only at period boundaries and on leaving STOPPED
wr_valid  input  1  shadow write request
wr_ready  output  1  shadow write accepted when high with wr_valid
wr_channel  input  chan_index_width  target channel
wr_rising  input  bitwidth  new rising tick number
wr_falling  input  bitwidth  new falling tick number
commit  input  1  pulse; request shadow-to-active transfer
commit_pending  output  1  high while a commit waits for a boundary
counter  output  bitwidth  time base to all timers
rising_edges  output  channels*bitwidth  active rising ticks; channel i at [i*bitwidth +: bitwidth]
falling_edges  output  channels*bitwidth  active falling ticks, same packing
period_start  output  1  high in every cycle where counter==0 and state is RUNNING or COMMIT_WAIT

Behaviour:
- Reset: state STOPPED; counter 0; period_latched 0; shadow and active registers all 0; commit_pending 0; wr_ready 1; period_start 0. All-zero active values mean falling equals rising, so timer outputs stay low.
- FSM states: STOPPED, RUNNING, COMMIT_WAIT.
- STOPPED: counter held at 0. enable=1 -> RUNNING; period_latched <= period on the same edge.
- RUNNING / COMMIT_WAIT with enable=1:
  - counter increments by 1 each cycle.
  - When counter==period_latched, the boundary occurs: counter <= 0 and period_latched <= period.
  - period_latched=0: counter stays 0 and every cycle is a boundary.
- enable=0 in RUNNING or COMMIT_WAIT -> STOPPED on the next edge with counter <= 0. A pending commit is applied on that same edge.
- Writes: wr_ready = (state != COMMIT_WAIT).
  - An accepted write updates that channel's shadow pair on the clock edge.
  - wr_channel >= channels: the write is accepted and discarded.
- Commit while STOPPED: active <= shadow on the next edge. A write accepted in the same cycle is included, via bypass.
- Commit while RUNNING -> COMMIT_WAIT. A write accepted in the same cycle is included in the committed set.
- COMMIT_WAIT: on the boundary edge, active <= shadow and state -> RUNNING. New values are therefore visible when counter==0.
- Commit while COMMIT_WAIT is ignored.
- commit_pending = (state == COMMIT_WAIT).
- Active values are never modified outside a commit.
- A period change takes effect only at a boundary, so counter never exceeds period_latched.

Optional Feature:
PWM_SCHEDULER_CENTER_ALIGNED_EN
- Defined:
  - The counter counts up 0..period_latched, then down period_latched-1..0.
  - Adds output port counting_down (1 bit; reset 0; high while decrementing).
  - The boundary is the edge on which counter reaches 0 while counting down. Commit and period latch occur there.
  - Full period is 2*period_latched cycles. period_latched=0 holds counter at 0 with every cycle a boundary.
  - period_start pulses at counter==0 in the running states.
- Undefined: sawtooth behaviour as above; no counting_down port.

Test Plan:
- Reset, then enable=1, period=4 -> counter 0,1,2,3,4,0,1; period_start high at each 0; outputs rising/falling all 0.
- Running (period=9): write ch2 rising=3 falling=7, commit at counter=5 -> commit_pending high, wr_ready low until the wrap; ch2 active values change exactly when counter returns to 0.
- STOPPED: write ch0 rising=1 and commit in the same cycle -> rising_edges[0] = 1 one cycle later; commit_pending never asserted.
- Change period 9->3 at counter=2 -> counter continues to 9, wraps to 0, then runs 0..3.
- enable dropped at counter=6 with commit pending -> next cycle counter=0, state STOPPED, active updated; write to wr_channel=3 with channels=3 is accepted and leaves all values unchanged.
- With PWM_SCHEDULER_CENTER_ALIGNED_EN, period=3 -> counter 0,1,2,3,2,1,0,1 with counting_down high during 2,1; a commit is applied at the down-count 0.

Source files
------------

// File: rtl/pwm_scheduler.sv
// Shared PWM time base with double-buffered per-channel rising/falling compare values.
// Define PWM_SCHEDULER_CENTER_ALIGNED_EN for an up/down counter with a counting_down output.
module pwm_scheduler #(
  parameter int bitwidth         = 10,
  parameter int channels         = 4,
  parameter int chan_index_width = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [bitwidth-1:0]          period,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [chan_index_width-1:0]  wr_channel,
  input  logic [bitwidth-1:0]          wr_rising,
  input  logic [bitwidth-1:0]          wr_falling,
  input  logic                         commit,
  output logic                         commit_pending,
  output logic [bitwidth-1:0]          counter,
  output logic [channels*bitwidth-1:0] rising_edges,
  output logic [channels*bitwidth-1:0] falling_edges,
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
  output logic                         counting_down,
`endif
  output logic                         period_start
);

  typedef enum logic [1:0] {STOPPED, RUNNING, COMMIT_WAIT} state_t;

  state_t              state_q, state_d;
  logic [bitwidth-1:0] counter_q, counter_d;
  logic [bitwidth-1:0] period_latched_q, period_latched_d;
  logic [bitwidth-1:0] shadow_rise_q [channels];
  logic [bitwidth-1:0] shadow_rise_d [channels];
  logic [bitwidth-1:0] shadow_fall_q [channels];
  logic [bitwidth-1:0] shadow_fall_d [channels];
  logic [bitwidth-1:0] active_rise_q [channels];
  logic [bitwidth-1:0] active_rise_d [channels];
  logic [bitwidth-1:0] active_fall_q [channels];
  logic [bitwidth-1:0] active_fall_d [channels];

  logic [bitwidth-1:0] step_counter;
  logic                step_boundary;
  logic                wr_fire;
  logic                apply_commit;

`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
  logic dir_q, dir_d;
  logic step_down;
  logic going_down;

  // Up to the top, back down; the boundary is the down-count arrival at 0.
  always_comb begin
    going_down    = dir_q || (counter_q == period_latched_q);
    step_counter  = going_down ? counter_q - bitwidth'(1) : counter_q + bitwidth'(1);
    step_boundary = going_down && (step_counter == '0);
    step_down     = going_down && !step_boundary;
    if (period_latched_q == '0) begin
      step_counter  = '0;
      step_boundary = 1'b1;
      step_down     = 1'b0;
    end
  end
`else
  always_comb begin
    step_boundary = (counter_q == period_latched_q);
    step_counter  = step_boundary ? '0 : counter_q + bitwidth'(1);
  end
`endif

  assign wr_fire = wr_valid && (state_q != COMMIT_WAIT);

  always_comb begin
    state_d          = state_q;
    counter_d        = counter_q;
    period_latched_d = period_latched_q;
    shadow_rise_d    = shadow_rise_q;
    shadow_fall_d    = shadow_fall_q;
    active_rise_d    = active_rise_q;
    active_fall_d    = active_fall_q;
    apply_commit     = 1'b0;
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
    dir_d            = dir_q;
`endif

    // Out-of-range channel indices match no entry and are silently dropped.
    for (int i = 0; i < channels; i++) begin
      if (wr_fire && (int'(wr_channel) == i)) begin
        shadow_rise_d[i] = wr_rising;
        shadow_fall_d[i] = wr_falling;
      end
    end

    case (state_q)
      STOPPED: begin
        counter_d = '0;
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
        dir_d     = 1'b0;
`endif
        apply_commit = commit;
        if (enable) begin
          state_d          = RUNNING;
          period_latched_d = period;
        end
      end
      RUNNING, COMMIT_WAIT: begin
        if (!enable) begin
          state_d      = STOPPED;
          counter_d    = '0;
          apply_commit = (state_q == COMMIT_WAIT) || commit;
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
          dir_d        = 1'b0;
`endif
        end else begin
          counter_d = step_counter;
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
          dir_d     = step_down;
`endif
          if (step_boundary) period_latched_d = period;
          if (state_q == COMMIT_WAIT) begin
            if (step_boundary) begin
              apply_commit = 1'b1;
              state_d      = RUNNING;
            end
          end else if (commit) begin
            state_d = COMMIT_WAIT;
          end
        end
      end
      default: state_d = STOPPED;
    endcase

    if (apply_commit) begin
      active_rise_d = shadow_rise_d;
      active_fall_d = shadow_fall_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= STOPPED;
      counter_q        <= '0;
      period_latched_q <= '0;
      shadow_rise_q    <= '{default: '0};
      shadow_fall_q    <= '{default: '0};
      active_rise_q    <= '{default: '0};
      active_fall_q    <= '{default: '0};
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
      dir_q            <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      counter_q        <= counter_d;
      period_latched_q <= period_latched_d;
      shadow_rise_q    <= shadow_rise_d;
      shadow_fall_q    <= shadow_fall_d;
      active_rise_q    <= active_rise_d;
      active_fall_q    <= active_fall_d;
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
      dir_q            <= dir_d;
`endif
    end
  end

  always_comb begin
    rising_edges  = '0;
    falling_edges = '0;
    for (int i = 0; i < channels; i++) begin
      rising_edges[i*bitwidth +: bitwidth]  = active_rise_q[i];
      falling_edges[i*bitwidth +: bitwidth] = active_fall_q[i];
    end
  end

  assign counter        = counter_q;
  assign wr_ready       = (state_q != COMMIT_WAIT);
  assign commit_pending = (state_q == COMMIT_WAIT);
  assign period_start   = (counter_q == '0) && (state_q != STOPPED);
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
  assign counting_down  = dir_q;
`endif

endmodule

// File: tb/tb_pwm_scheduler.sv
// Directed self-checking bench for pwm_scheduler (3 channels, 10-bit time base).
// Center-aligned checks compile in when PWM_SCHEDULER_CENTER_ALIGNED_EN is defined.
module tb_pwm_scheduler;
  localparam int BW = 10;
  localparam int CH = 3;
  localparam int CIW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [BW-1:0]     period;
  logic              wr_valid;
  logic              wr_ready;
  logic [CIW-1:0]    wr_channel;
  logic [BW-1:0]     wr_rising;
  logic [BW-1:0]     wr_falling;
  logic              commit;
  logic              commit_pending;
  logic [BW-1:0]     counter;
  logic [CH*BW-1:0]  rising_edges;
  logic [CH*BW-1:0]  falling_edges;
  logic              period_start;
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
  logic              counting_down;
`endif

  int total = 0;
  int bad = 0;

  pwm_scheduler #(.bitwidth(BW), .channels(CH), .chan_index_width(CIW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .period(period),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_channel(wr_channel),
    .wr_rising(wr_rising), .wr_falling(wr_falling), .commit(commit),
    .commit_pending(commit_pending), .counter(counter),
    .rising_edges(rising_edges), .falling_edges(falling_edges),
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
    .counting_down(counting_down),
`endif
    .period_start(period_start)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BW-1:0] rise_of(input int ch);
    return rising_edges[ch*BW +: BW];
  endfunction

  function automatic logic [BW-1:0] fall_of(input int ch);
    return falling_edges[ch*BW +: BW];
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; period = '0; wr_valid = 1'b0; wr_channel = '0;
    wr_rising = '0; wr_falling = '0; commit = 1'b0;
    tick(); tick();
    total++; if (counter !== 10'd0) begin bad++; $display("[TB] FAIL reset_counter got=%0d want=0", counter); end
    total++; if (commit_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending got=%b want=0", commit_pending); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", wr_ready); end
    total++; if (period_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_pstart got=%b want=0", period_start); end
    total++; if (rising_edges !== '0 || falling_edges !== '0) begin bad++; $display("[TB] FAIL reset_edges got=%h/%h want=0", rising_edges, falling_edges); end
    reset = 1'b0;
    tick();
    total++; if (counter !== 10'd0 || period_start !== 1'b0) begin bad++; $display("[TB] FAIL stopped_idle got=%0d/%b want=0/0", counter, period_start); end
  endtask

  task automatic test_sawtooth();
    int exp_cnt [7] = '{0, 1, 2, 3, 4, 0, 1};
    period = 10'd4; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++; if (counter !== 10'(exp_cnt[i])) begin bad++; $display("[TB] FAIL saw_counter[%0d] got=%0d want=%0d", i, counter, exp_cnt[i]); end
      total++; if (period_start !== (exp_cnt[i] == 0)) begin bad++; $display("[TB] FAIL saw_pstart[%0d] got=%b want=%b", i, period_start, exp_cnt[i] == 0); end
    end
    total++; if (rising_edges !== '0 || falling_edges !== '0) begin bad++; $display("[TB] FAIL saw_edges got=%h/%h want=0", rising_edges, falling_edges); end
    enable = 1'b0;
    tick();
    total++; if (counter !== 10'd0 || period_start !== 1'b0) begin bad++; $display("[TB] FAIL saw_stop got=%0d/%b want=0/0", counter, period_start); end
  endtask

  task automatic test_commit_running();
    period = 10'd9; enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    total++; if (counter !== 10'd5) begin bad++; $display("[TB] FAIL cr_start got=%0d want=5", counter); end
    wr_valid = 1'b1; wr_channel = 2'd2; wr_rising = 10'd3; wr_falling = 10'd7; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      total++; if (counter !== 10'(c)) begin bad++; $display("[TB] FAIL cr_counter got=%0d want=%0d", counter, c); end
      total++; if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL cr_wait@%0d got=%b/%b want=1/0", c, commit_pending, wr_ready); end
      total++; if (rise_of(2) !== 10'd0 || fall_of(2) !== 10'd0) begin bad++; $display("[TB] FAIL cr_early@%0d got=%0d/%0d want=0/0", c, rise_of(2), fall_of(2)); end
      // A write offered while the commit waits must be refused.
      wr_valid = (c == 7); wr_channel = 2'd1; wr_rising = 10'd9; wr_falling = 10'd9;
      tick();
    end
    wr_valid = 1'b0;
    total++; if (counter !== 10'd0 || period_start !== 1'b1) begin bad++; $display("[TB] FAIL cr_wrap got=%0d/%b want=0/1", counter, period_start); end
    total++; if (rise_of(2) !== 10'd3 || fall_of(2) !== 10'd7) begin bad++; $display("[TB] FAIL cr_applied got=%0d/%0d want=3/7", rise_of(2), fall_of(2)); end
    total++; if (commit_pending !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL cr_release got=%b/%b want=0/1", commit_pending, wr_ready); end
    total++; if (rise_of(1) !== 10'd0) begin bad++; $display("[TB] FAIL cr_refused got=%0d want=0", rise_of(1)); end
  endtask

  task automatic test_period_change();
    int exp_cnt [12] = '{3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 0};
    tick(); tick();
    total++; if (counter !== 10'd2) begin bad++; $display("[TB] FAIL pc_start got=%0d want=2", counter); end
    period = 10'd3;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++; if (counter !== 10'(exp_cnt[i])) begin bad++; $display("[TB] FAIL pc_counter[%0d] got=%0d want=%0d", i, counter, exp_cnt[i]); end
    end
  endtask

  task automatic test_stop_with_commit();
    int guard;
    period = 10'd9;
    guard = 0;
    while (counter !== 10'd4 && guard < 40) begin tick(); guard++; end
    total++; if (counter !== 10'd4) begin bad++; $display("[TB] FAIL sc_reach4 got=%0d want=4", counter); end
    wr_valid = 1'b1; wr_channel = 2'd0; wr_rising = 10'd5; wr_falling = 10'd6; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    tick();
    total++; if (counter !== 10'd6 || commit_pending !== 1'b1) begin bad++; $display("[TB] FAIL sc_pending got=%0d/%b want=6/1", counter, commit_pending); end
    enable = 1'b0;
    tick();
    total++; if (counter !== 10'd0 || commit_pending !== 1'b0 || period_start !== 1'b0) begin bad++; $display("[TB] FAIL sc_stopped got=%0d/%b/%b want=0/0/0", counter, commit_pending, period_start); end
    total++; if (rising_edges !== {10'd3, 10'd0, 10'd5} || falling_edges !== {10'd7, 10'd0, 10'd6}) begin bad++; $display("[TB] FAIL sc_applied got=%h/%h want=%h/%h", rising_edges, falling_edges, {10'd3, 10'd0, 10'd5}, {10'd7, 10'd0, 10'd6}); end
    wr_valid = 1'b1; wr_channel = 2'd3; wr_rising = 10'd1; wr_falling = 10'd2; commit = 1'b1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL sc_oob_ready got=%b want=1", wr_ready); end
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    tick();
    total++; if (rising_edges !== {10'd3, 10'd0, 10'd5} || falling_edges !== {10'd7, 10'd0, 10'd6}) begin bad++; $display("[TB] FAIL sc_oob_discard got=%h/%h want=unchanged", rising_edges, falling_edges); end
  endtask

  task automatic test_stopped_bypass();
    wr_valid = 1'b1; wr_channel = 2'd0; wr_rising = 10'd1; wr_falling = 10'd8; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    total++; if (rise_of(0) !== 10'd1 || fall_of(0) !== 10'd8) begin bad++; $display("[TB] FAIL bp_applied got=%0d/%0d want=1/8", rise_of(0), fall_of(0)); end
    total++; if (commit_pending !== 1'b0 || counter !== 10'd0) begin bad++; $display("[TB] FAIL bp_state got=%b/%0d want=0/0", commit_pending, counter); end
  endtask

`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
  task automatic test_center_aligned();
    int   exp_cnt  [6] = '{2, 3, 2, 1, 0, 1};
    logic exp_down [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   exp_rise [6] = '{0, 0, 0, 0, 2, 2};
    period = 10'd3; enable = 1'b1;
    tick(); tick();
    total++; if (counter !== 10'd1 || counting_down !== 1'b0) begin bad++; $display("[TB] FAIL ca_start got=%0d/%b want=1/0", counter, counting_down); end
    wr_valid = 1'b1; wr_channel = 2'd1; wr_rising = 10'd2; wr_falling = 10'd3; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (counter !== 10'(exp_cnt[i]) || counting_down !== exp_down[i]) begin bad++; $display("[TB] FAIL ca_step[%0d] got=%0d/%b want=%0d/%b", i, counter, counting_down, exp_cnt[i], exp_down[i]); end
      total++; if (rise_of(1) !== 10'(exp_rise[i])) begin bad++; $display("[TB] FAIL ca_rise[%0d] got=%0d want=%0d", i, rise_of(1), exp_rise[i]); end
      total++; if (period_start !== (exp_cnt[i] == 0)) begin bad++; $display("[TB] FAIL ca_pstart[%0d] got=%b want=%b", i, period_start, exp_cnt[i] == 0); end
      tick();
    end
    enable = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sawtooth();
    test_commit_running();
    test_period_change();
    test_stop_with_commit();
    test_stopped_bypass();
`ifdef PWM_SCHEDULER_CENTER_ALIGNED_EN
    test_center_aligned();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
